// File: rtl/cke_meter_pkg.sv
// Shared types for the clock-enable strobe meter.
package cke_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        MEAS = 2'd2
    } cke_meter_state_e;

endpackage

// File: rtl/cke_meter_risedet.sv
// Rising-edge detector for clk-synchronous strobes. The history flop resets high,
// so a strobe that is already high when reset releases is not reported as an edge.
module risedet (
    input  logic clk,
    input  logic rst_,
    input  logic d,
    output logic rise
);

    logic prev_d;
    logic prev_q;

    // Next value of the history flop: the current strobe level.
    always_comb begin
        prev_d = d;
    end

    // History flop, sampled every cycle.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = d & ~prev_q;

endmodule

// File: rtl/cke_meter.sv
// Measures period and high time of a clk-synchronous cke strobe, in clk cycles,
// with a one-cycle valid pulse per result and a sticky timeout.
module cke_meter
    import cke_meter_pkg::*;
#(
    parameter int MAXT = 50000000,
    parameter int W    = $clog2(MAXT + 1)
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         ena,
    input  logic         cke,
    output logic [W-1:0] period,
    output logic [W-1:0] high,
    output logic         valid,
    output logic         timeout
);

    localparam logic [W-1:0] ZERO   = {W{1'b0}};
    localparam logic [W-1:0] ONE    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] MAXT_W = W'(MAXT);

    logic             rise;
    cke_meter_state_e state_d, state_q;
    logic [W-1:0]     cnt_d, cnt_q;
    logic [W-1:0]     hcnt_d, hcnt_q;
    logic [W-1:0]     period_d, period_q;
    logic [W-1:0]     high_d, high_q;
    logic             valid_d, valid_q;
    logic             timeout_d, timeout_q;

    risedet u_risedet (
        .clk  (clk),
        .rst_ (rst_),
        .d    (cke),
        .rise (rise)
    );

    // Next-state, counter and result computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;

        if (!ena) begin
            // Disable overrides everything, including a coincident rise.
            state_d   = IDLE;
            cnt_d     = ZERO;
            hcnt_d    = ZERO;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SYNC;
                    cnt_d   = ZERO;
                    hcnt_d  = ZERO;
                end
                SYNC: begin
                    if (rise) begin
                        state_d = MEAS;
                        cnt_d   = ONE;
                        hcnt_d  = ONE;
                    end else begin
                        state_d = SYNC;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        period_d  = cnt_q;
                        high_d    = hcnt_q;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                        cnt_d     = ONE;
                        hcnt_d    = ONE;
                    end else if (cnt_q == MAXT_W) begin
                        // Timeout bounds the counters, so they never wrap.
                        timeout_d = 1'b1;
                        state_d   = SYNC;
                        cnt_d     = ZERO;
                        hcnt_d    = ZERO;
                    end else begin
                        cnt_d  = cnt_q + ONE;
                        hcnt_d = hcnt_q + {{(W-1){1'b0}}, cke};
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = ZERO;
                    hcnt_d  = ZERO;
                end
            endcase
        end
    end

    // State, counters and registered results.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q   <= IDLE;
            cnt_q     <= ZERO;
            hcnt_q    <= ZERO;
            period_q  <= ZERO;
            high_q    <= ZERO;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign period  = period_q;
    assign high    = high_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_cke_meter.sv
// Directed bench for cke_meter with MAXT = 8.
module tb_cke_meter;

    localparam int MAXT = 8;
    localparam int W    = $clog2(MAXT + 1);

    logic         clk;
    logic         rst_;
    logic         ena;
    logic         cke;
    logic [W-1:0] period;
    logic [W-1:0] high;
    logic         valid;
    logic         timeout;

    int n_vec;
    int n_err;

    cke_meter #(.MAXT(MAXT)) dut (
        .clk     (clk),
        .rst_    (rst_),
        .ena     (ena),
        .cke     (cke),
        .period  (period),
        .high    (high),
        .valid   (valid),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cke sample, let the clock edge take it, then check every output.
    task automatic step(input string tag, input logic c, input logic v,
                        input int p, input int h, input logic to);
        cke = c;
        @(posedge clk);
        #1;
        chk({tag, ".valid"},   {31'd0, valid},   {31'd0, v});
        chk({tag, ".period"},  {28'd0, period},  p);
        chk({tag, ".high"},    {28'd0, high},    h);
        chk({tag, ".timeout"}, {31'd0, timeout}, {31'd0, to});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_  = 1'b0;
        ena   = 1'b0;
        cke   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.period",  {28'd0, period},  32'd0);
        chk("rst.high",    {28'd0, high},    32'd0);
        chk("rst.valid",   {31'd0, valid},   32'd0);
        chk("rst.timeout", {31'd0, timeout}, 32'd0);
        rst_ = 1'b1;
        ena  = 1'b1;
        step("en", 1'b0, 1'b0, 0, 0, 1'b0);

        // T=4 splitter pattern 1,1,0,0; the first rise only synchronises.
        for (int r = 0; r < 3; r++) begin
            step("t4r", 1'b1, (r != 0), (r == 0) ? 0 : 4, (r == 0) ? 0 : 2, 1'b0);
            step("t4",  1'b1, 1'b0,     (r == 0) ? 0 : 4, (r == 0) ? 0 : 2, 1'b0);
            step("t4",  1'b0, 1'b0,     (r == 0) ? 0 : 4, (r == 0) ? 0 : 2, 1'b0);
            step("t4",  1'b0, 1'b0,     (r == 0) ? 0 : 4, (r == 0) ? 0 : 2, 1'b0);
        end

        // Minimum period 2: pattern 1,0.
        step("p2r0", 1'b1, 1'b1, 4, 2, 1'b0);
        step("p2",   1'b0, 1'b0, 4, 2, 1'b0);
        for (int r = 0; r < 3; r++) begin
            step("p2r", 1'b1, 1'b1, 2, 1, 1'b0);
            step("p2",  1'b0, 1'b0, 2, 1, 1'b0);
        end

        // Pattern 1,0,0,0,0.
        for (int r = 0; r < 3; r++) begin
            step("p5r", 1'b1, 1'b1, (r == 0) ? 2 : 5, 1, 1'b0);
            for (int k = 0; k < 4; k++)
                step("p5", 1'b0, 1'b0, (r == 0) ? 2 : 5, 1, 1'b0);
        end

        // cke held high after a rise: timeout exactly MAXT cycles later.
        step("to.rise", 1'b1, 1'b1, 5, 1, 1'b0);
        for (int k = 0; k < 7; k++)
            step("to.wait", 1'b1, 1'b0, 5, 1, 1'b0);
        step("to.set",  1'b1, 1'b0, 5, 1, 1'b1);
        step("to.hold", 1'b1, 1'b0, 5, 1, 1'b1);
        step("to.low",  1'b0, 1'b0, 5, 1, 1'b1);
        step("to.sync", 1'b1, 1'b0, 5, 1, 1'b1);
        step("to.a",    1'b0, 1'b0, 5, 1, 1'b1);
        step("to.b",    1'b0, 1'b0, 5, 1, 1'b1);
        step("to.clr",  1'b1, 1'b1, 3, 1, 1'b0);

        // Rise coinciding with cnt == MAXT wins over timeout.
        for (int k = 0; k < 7; k++)
            step("edge.wait", 1'b0, 1'b0, 3, 1, 1'b0);
        step("edge.rise", 1'b1, 1'b1, 8, 1, 1'b0);

        // ena dropped mid-period: no valid, old period kept, rise in IDLE ignored.
        step("dis.a", 1'b0, 1'b0, 8, 1, 1'b0);
        ena = 1'b0;
        step("dis.idle", 1'b0, 1'b0, 8, 1, 1'b0);
        step("dis.rise", 1'b1, 1'b0, 8, 1, 1'b0);
        ena = 1'b1;
        step("ree.sync", 1'b0, 1'b0, 8, 1, 1'b0);
        step("ree.r1",   1'b1, 1'b0, 8, 1, 1'b0);
        step("ree.a",    1'b0, 1'b0, 8, 1, 1'b0);
        step("ree.b",    1'b0, 1'b0, 8, 1, 1'b0);
        step("ree.r2",   1'b1, 1'b1, 3, 1, 1'b0);

        // ena falling together with a rise: disable wins.
        step("coin.a", 1'b0, 1'b0, 3, 1, 1'b0);
        ena = 1'b0;
        step("coin.rise", 1'b1, 1'b0, 3, 1, 1'b0);
        ena = 1'b1;
        step("coin.sync", 1'b0, 1'b0, 3, 1, 1'b0);

        // Reset mid-measurement with cke high: immediate clear, no false rise after release.
        step("mr.r1", 1'b1, 1'b0, 3, 1, 1'b0);
        step("mr.a",  1'b1, 1'b0, 3, 1, 1'b0);
        #2;
        rst_ = 1'b0;
        #1;
        chk("mr.async.period", {28'd0, period}, 32'd0);
        chk("mr.async.high",   {28'd0, high},   32'd0);
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        step("mr.en",   1'b1, 1'b0, 0, 0, 1'b0);
        step("mr.hi1",  1'b1, 1'b0, 0, 0, 1'b0);
        step("mr.hi2",  1'b1, 1'b0, 0, 0, 1'b0);
        step("mr.lo",   1'b0, 1'b0, 0, 0, 1'b0);
        step("mr.sync", 1'b1, 1'b0, 0, 0, 1'b0);
        step("mr.lo2",  1'b0, 1'b0, 0, 0, 1'b0);
        step("mr.meas", 1'b1, 1'b1, 2, 1, 1'b0);
        step("mr.end",  1'b0, 1'b0, 2, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
